followed_by_checker: RTL and testbench
======================================

// Module: followed_by_checker
// PURPOSE
//   Synthesizable multi-channel checker for "ante followed-by cons after DELAY cycles".
//   DELAY=0 gives #-# / |-> semantics; DELAY=1 gives #=# / |=>; DELAY>1 is ##DELAY.
//   Sits beside the design under test in regression benches and FPGA builds.
//   Reports per-channel fail pulses and saturating error counts.
// PARAMETERS
//   NUM_CH  4  number of independent ante/cons channels (1..32)
//   DELAY   1  cycles from ante sample to cons sample (0..15)
//   CNT_W   8  width of each per-channel error counter (2..16)
// PORTS
//   clk        in   1             sampling clock, all checks on posedge
//   rst        in   1             asynchronous, active-high reset
//   disable_i  in   1             "disable iff": aborts checking while high
//   clr_cnt    in   1             synchronous clear of all counters
//   ante       in   NUM_CH        antecedent per channel
//   cons       in   NUM_CH        consequent per channel
//   fail       out  NUM_CH        one-cycle fail pulse per channel
//   fail_any   out  1             OR of fail
//   err_cnt    out  NUM_CH*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W]
//   pass_cnt   out  NUM_CH*CNT_W  packed pass counters (only with FBCHK_COVER_EN)
// BEHAVIOUR
//   - Reset: pending pipelines, fail, fail_any, err_cnt and pass_cnt all 0.
//   - Obligation: at a posedge with ante[i]=1 and disable_i=0, channel i owes cons[i]=1
//     at the posedge DELAY cycles later. Overlapping obligations are tracked independently.
//   - Storage: per channel a DELAY-bit shift register pend[i]. Bit 0 loads ante&~disable.
//     Bit DELAY-1 is the obligation due this edge. DELAY=0 has no storage; the due term is
//     ante&~disable.
//   - Check: at each edge, due=1 and cons=0 and disable_i=0 -> violation. due=1 and cons=1
//     -> pass.
//   - Latency: fail[i] is registered, high exactly one cycle, the cycle after the
//     violating edge.
//   - fail_any is registered with fail, so it goes high in the same cycle.
//   - Disable: disable_i=1 at an edge clears all pend bits. That edge launches no new
//     obligation and makes no check; nothing is reported for aborted obligations.
//     Checking resumes at the first edge with disable_i=0.
//   - err_cnt[i] increments by 1 per violation and saturates at 2^CNT_W-1, with no wrap.
//   - clr_cnt=1 at an edge: counter <= (violation at that edge ? 1 : 0). clr wins over the
//     old value, but a same-edge event is still counted.
//   - Channels are fully independent; simultaneous violations each produce their own pulse.
//   - Reset mid-operation drops all pending obligations immediately, with no fail
//     generated.
//   - X on ante/cons is treated as 0 for obligations and as a failed consequent for checks.
// CONFIGURATION
//   FBCHK_COVER_EN defined: pass_cnt is present. It counts discharged obligations per
//     channel, using the same saturation and clr_cnt rules as err_cnt.
//   FBCHK_COVER_EN undefined: no pass_cnt port and no pass counter logic; all other
//     behaviour is identical.
// TESTING
//   1) NUM_CH=1, DELAY=1. Six-cycle stimulus:
//      - ante=1 at cyc0 and cyc3, cons=1 at cyc1 and cyc4.
//      - Required: fail never set, err_cnt=0, pass_cnt=2 (COVER).
//   2) DELAY=1, ante=1 at cyc3, cons=0 at cyc4 ->
//      - fail pulses in cyc5 only.
//      - fail_any pulses in cyc5 only.
//      - err_cnt=1.
//   3) DELAY=0, ante=1 and cons=0 at the same edge -> fail next cycle.
//      - With cons=1 at that edge: no fail.
//   4) DELAY=3, ante at cyc2, disable_i=1 at cyc4, cons=0 at cyc5 ->
//      - no fail, err_cnt=0.
//      - ante at cyc6 and cons=0 at cyc9 -> fail in cyc10.
//   5) CNT_W=2, five violations -> err_cnt=3.
//      - clr_cnt at an edge with no violation -> err_cnt=0.
//      - clr_cnt on a violating edge -> err_cnt=1.
//   6) NUM_CH=4, DELAY=2, ante=4'b1111 at cyc1, rst pulsed at cyc2 ->
//      - no fail pulses, all counters 0.
//      - ch0..3 checked independently afterwards.

Source files
------------

// File: rtl/followed_by_checker.sv
// Multi-channel "ante followed-by cons after DELAY cycles" checker with per-channel fail pulses
// and saturating error counters. Defining FBCHK_COVER_EN adds per-channel pass counters (pass_cnt).
module followed_by_checker #(
  parameter int NUM_CH = 4,
  parameter int DELAY  = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disable_i,
  input  logic                    clr_cnt,
  input  logic [NUM_CH-1:0]       ante,
  input  logic [NUM_CH-1:0]       cons,
  output logic [NUM_CH-1:0]       fail,
  output logic                    fail_any,
  output logic [NUM_CH*CNT_W-1:0] err_cnt
`ifdef FBCHK_COVER_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt
`endif
);

  logic [NUM_CH-1:0]       ante_ok;
  logic [NUM_CH-1:0]       cons_ok;
  logic [NUM_CH-1:0]       due;
  logic [NUM_CH-1:0]       viol;
  logic [NUM_CH-1:0]       fail_q, fail_d;
  logic                    fail_any_q, fail_any_d;
  logic [NUM_CH*CNT_W-1:0] err_q, err_d;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic clr, input logic ev);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = {{(CNT_W-1){1'b0}}, ev};
    end else if (ev && (cnt != {CNT_W{1'b1}})) begin
      nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // An if() on an unknown takes the else branch, so X never launches an obligation
  // and never counts as a good consequent.
  always_comb begin
    ante_ok = '0;
    cons_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ante[i]) ante_ok[i] = 1'b1;
      if (cons[i]) cons_ok[i] = 1'b1;
    end
  end

  generate
    if (DELAY == 0) begin : g_nodelay
      assign due = ante_ok & {NUM_CH{~disable_i}};
    end else begin : g_delay
      // Channel i owns pend[i*DELAY +: DELAY]; bit 0 is the newest obligation.
      logic [NUM_CH*DELAY-1:0] pend_q, pend_d;
      logic [DELAY:0]          shifted;

      always_comb begin
        pend_d  = '0;
        shifted = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          shifted = {pend_q[i*DELAY +: DELAY], ante_ok[i]};
          if (!disable_i) pend_d[i*DELAY +: DELAY] = shifted[DELAY-1:0];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
      end

      for (genvar i = 0; i < NUM_CH; i++) begin : g_due
        assign due[i] = pend_q[i*DELAY + DELAY - 1];
      end
    end
  endgenerate

  assign viol = due & ~cons_ok & {NUM_CH{~disable_i}};

  always_comb begin
    fail_d     = viol;
    fail_any_d = |viol;
    err_d      = err_q;
    for (int i = 0; i < NUM_CH; i++) begin
      err_d[i*CNT_W +: CNT_W] = cnt_next(err_q[i*CNT_W +: CNT_W], clr_cnt, viol[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q     <= '0;
      fail_any_q <= 1'b0;
      err_q      <= '0;
    end else begin
      fail_q     <= fail_d;
      fail_any_q <= fail_any_d;
      err_q      <= err_d;
    end
  end

  assign fail     = fail_q;
  assign fail_any = fail_any_q;
  assign err_cnt  = err_q;

`ifdef FBCHK_COVER_EN
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH*CNT_W-1:0] pass_q, pass_d;

  assign hit = due & cons_ok & {NUM_CH{~disable_i}};

  always_comb begin
    pass_d = pass_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_d[i*CNT_W +: CNT_W] = cnt_next(pass_q[i*CNT_W +: CNT_W], clr_cnt, hit[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pass_q <= '0;
    else     pass_q <= pass_d;
  end

  assign pass_cnt = pass_q;
`endif

endmodule

// File: tb/tb_followed_by_checker.sv
// Bench for followed_by_checker: five configurations share one stimulus stream and are
// compared every cycle against a history-based model of the followed-by rule.
module tb_followed_by_checker;

  localparam int NI   = 5;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       disable_i;
  logic       clr_cnt;
  logic [3:0] ante;
  logic [3:0] cons;

  logic [3:0]  fail_a, fail_b, fail_c, fail_d;
  logic [0:0]  fail_e;
  logic        fany_a, fany_b, fany_c, fany_d, fany_e;
  logic [31:0] err_a;
  logic [7:0]  err_b;
  logic [11:0] err_c;
  logic [31:0] err_d;
  logic [3:0]  err_e;
`ifdef FBCHK_COVER_EN
  logic [31:0] pass_a;
  logic [7:0]  pass_b;
  logic [11:0] pass_c;
  logic [31:0] pass_d;
  logic [3:0]  pass_e;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  followed_by_checker #(.NUM_CH(4), .DELAY(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .disable_i(disable_i), .clr_cnt(clr_cnt), .ante(ante), .cons(cons),
    .fail(fail_a), .fail_any(fany_a), .err_cnt(err_a)
`ifdef FBCHK_COVER_EN
    , .pass_cnt(pass_a)
`endif
  );
  followed_by_checker #(.NUM_CH(4), .DELAY(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .disable_i(disable_i), .clr_cnt(clr_cnt), .ante(ante), .cons(cons),
    .fail(fail_b), .fail_any(fany_b), .err_cnt(err_b)
`ifdef FBCHK_COVER_EN
    , .pass_cnt(pass_b)
`endif
  );
  followed_by_checker #(.NUM_CH(4), .DELAY(3), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .disable_i(disable_i), .clr_cnt(clr_cnt), .ante(ante), .cons(cons),
    .fail(fail_c), .fail_any(fany_c), .err_cnt(err_c)
`ifdef FBCHK_COVER_EN
    , .pass_cnt(pass_c)
`endif
  );
  followed_by_checker #(.NUM_CH(4), .DELAY(2), .CNT_W(8)) u_d (
    .clk(clk), .rst(rst), .disable_i(disable_i), .clr_cnt(clr_cnt), .ante(ante), .cons(cons),
    .fail(fail_d), .fail_any(fany_d), .err_cnt(err_d)
`ifdef FBCHK_COVER_EN
    , .pass_cnt(pass_d)
`endif
  );
  followed_by_checker #(.NUM_CH(1), .DELAY(1), .CNT_W(4)) u_e (
    .clk(clk), .rst(rst), .disable_i(disable_i), .clr_cnt(clr_cnt), .ante(ante[0:0]),
    .cons(cons[0:0]), .fail(fail_e), .fail_any(fany_e), .err_cnt(err_e)
`ifdef FBCHK_COVER_EN
    , .pass_cnt(pass_e)
`endif
  );

  // ---------------- configuration table and output access ----------------
  function automatic int dly(input int k);
    case (k) 0: return 1; 1: return 0; 2: return 3; 3: return 2; default: return 1; endcase
  endfunction
  function automatic int cw(input int k);
    case (k) 0: return 8; 1: return 2; 2: return 3; 3: return 8; default: return 4; endcase
  endfunction
  function automatic int nch(input int k);
    return (k == 4) ? 1 : 4;
  endfunction

  function automatic logic [3:0] get_fail(input int k);
    case (k) 0: return fail_a; 1: return fail_b; 2: return fail_c; 3: return fail_d;
      default: return {3'b000, fail_e}; endcase
  endfunction
  function automatic logic get_fany(input int k);
    case (k) 0: return fany_a; 1: return fany_b; 2: return fany_c; 3: return fany_d;
      default: return fany_e; endcase
  endfunction
  function automatic logic [31:0] get_err(input int k);
    case (k) 0: return err_a; 1: return {24'd0, err_b}; 2: return {20'd0, err_c};
      3: return err_d; default: return {28'd0, err_e}; endcase
  endfunction
  function automatic int slice(input logic [31:0] v, input int k, input int i);
    logic [31:0] m;
    m = (32'd1 << cw(k)) - 32'd1;
    return int'((v >> (i * cw(k))) & m);
  endfunction
  function automatic int act_err(input int k, input int i);
    return slice(get_err(k), k, i);
  endfunction
`ifdef FBCHK_COVER_EN
  function automatic logic [31:0] get_pass(input int k);
    case (k) 0: return pass_a; 1: return {24'd0, pass_b}; 2: return {20'd0, pass_c};
      3: return pass_d; default: return {28'd0, pass_e}; endcase
  endfunction
`endif

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: obligations looked up in edge history ----------------
  logic [3:0] ante_h [HMAX];
  logic [3:0] cons_h [HMAX];
  bit         dis_h  [HMAX];
  bit         clr_h  [HMAX];
  int         ep_h   [HMAX];
  int         t = 0;
  int         epoch = 0;
  int         last_epoch = 0;
  bit         started = 1'b0;
  int         exp_err  [NI][4];
  int         exp_pass [NI][4];
  bit         exp_fail [NI][4];

  // Obligation owed on channel i at edge tt: ante sampled DELAY edges earlier while enabled,
  // with no disable in between and no reset since.
  function automatic bit owed(input int k, input int i, input int tt);
    int d;
    int s;
    d = dly(k);
    if (d == 0) return (ante_h[tt][i] === 1'b1) && !dis_h[tt];
    s = tt - d;
    if (s < 0) return 1'b0;
    if ((ante_h[s][i] !== 1'b1) || dis_h[s] || (ep_h[s] != ep_h[tt])) return 1'b0;
    for (int u = s + 1; u < tt; u++) if (dis_h[u]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bump(input int cnt, input bit clr, input bit ev, input int k);
    int mx;
    mx = (1 << cw(k)) - 1;
    if (clr) return ev ? 1 : 0;
    if (ev && cnt < mx) return cnt + 1;
    return cnt;
  endfunction

  initial begin
    bit due;
    bit c_ok;
    bit v;
    bit p;
    bit any;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 4; i++) begin
        exp_err[k][i] = 0; exp_pass[k][i] = 0; exp_fail[k][i] = 1'b0;
      end
    wait (started);
    forever begin
      @(negedge clk);
      if (epoch != last_epoch) begin
        last_epoch = epoch;
        for (int k = 0; k < NI; k++)
          for (int i = 0; i < 4; i++) begin
            exp_err[k][i] = 0; exp_pass[k][i] = 0; exp_fail[k][i] = 1'b0;
          end
      end
      if (t < HMAX) begin
        ante_h[t] = ante; cons_h[t] = cons; dis_h[t] = disable_i; clr_h[t] = clr_cnt;
        ep_h[t] = epoch;
        for (int k = 0; k < NI; k++) begin
          any = 1'b0;
          for (int i = 0; i < nch(k); i++) begin
            due  = owed(k, i, t);
            c_ok = (cons_h[t][i] === 1'b1);
            v    = due && !dis_h[t] && !c_ok;
            p    = due && !dis_h[t] && c_ok;
            exp_fail[k][i] = v;
            any = any | v;
            exp_err[k][i]  = bump(exp_err[k][i], clr_h[t], v, k);
            exp_pass[k][i] = bump(exp_pass[k][i], clr_h[t], p, k);
            check($sformatf("fail[%0d].ch%0d", k, i), int'(get_fail(k)[i]), int'(v));
            check($sformatf("err_cnt[%0d].ch%0d", k, i), act_err(k, i), exp_err[k][i]);
`ifdef FBCHK_COVER_EN
            check($sformatf("pass_cnt[%0d].ch%0d", k, i), slice(get_pass(k), k, i),
                  exp_pass[k][i]);
`endif
          end
          check($sformatf("fail_any[%0d]", k), int'(get_fany(k)), int'(any));
        end
        t++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] a, input logic [3:0] c, input bit dis, input bit clr,
                      input bit do_rst);
    ante = a; cons = c; disable_i = dis; clr_cnt = clr;
    if (do_rst) begin
      rst = 1'b1;
      epoch++;
      #1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("rst_err[%0d]", k), int'(get_err(k)), 0);
        check($sformatf("rst_fail[%0d]", k), int'(get_fail(k)), 0);
      end
      #1;
      rst = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Flush all pending obligations and zero every counter in one edge.
  task automatic prep();
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [3:0] c;
    rst = 1'b1; disable_i = 1'b0; clr_cnt = 1'b0; ante = 4'h0; cons = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_fail[%0d]", k), int'(get_fail(k)), 0);
      check($sformatf("reset_fany[%0d]", k), int'(get_fany(k)), 0);
      check($sformatf("reset_err[%0d]", k), int'(get_err(k)), 0);
`ifdef FBCHK_COVER_EN
      check($sformatf("reset_pass[%0d]", k), int'(get_pass(k)), 0);
`endif
    end
    #2;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    #1;

    // DELAY=1: two discharged obligations, no failures
    prep();
    step(4'h1, 4'h0, 0, 0, 0); step(4'h0, 4'h1, 0, 0, 0); idle(1);
    step(4'h1, 4'h0, 0, 0, 0); step(4'h0, 4'h1, 0, 0, 0); idle(1);
    check("s1_err_e", act_err(4, 0), 0);
    check("s1_err_a", act_err(0, 0), 0);
    check("s1_fail_e", int'(get_fail(4)), 0);
`ifdef FBCHK_COVER_EN
    check("s1_pass_e", slice(get_pass(4), 4, 0), 2);
    check("s1_pass_a", slice(get_pass(0), 0, 0), 2);
`endif

    // DELAY=1: ante at cyc3, cons low at cyc4, pulse in cyc5 only
    prep();
    idle(3);
    step(4'h1, 4'h0, 0, 0, 0);
    check("s2_fail_before", int'(get_fail(0)), 0);
    idle(1);
    check("s2_fail_a", int'(get_fail(0)), 1);
    check("s2_fany_a", int'(get_fany(0)), 1);
    check("s2_err_a", act_err(0, 0), 1);
    check("s2_err_e", act_err(4, 0), 1);
    idle(1);
    check("s2_fail_after", int'(get_fail(0)), 0);
    check("s2_fany_after", int'(get_fany(0)), 0);

    // DELAY=0: same-edge check
    prep();
    step(4'h1, 4'h0, 0, 0, 0);
    check("s3_fail_b", int'(get_fail(1)), 1);
    check("s3_err_b", act_err(1, 0), 1);
    step(4'h1, 4'h1, 0, 0, 0);
    check("s3_nofail_b", int'(get_fail(1)), 0);
    check("s3_err_b_hold", act_err(1, 0), 1);

    // DELAY=3: disable aborts the obligation, later one still fails
    prep();
    idle(2);
    step(4'h1, 4'h0, 0, 0, 0); idle(1);
    step(4'h0, 4'h0, 1, 0, 0); idle(1);
    check("s4_err_c_abort", act_err(2, 0), 0);
    check("s4_fail_c_abort", int'(get_fail(2)), 0);
    step(4'h1, 4'h0, 0, 0, 0); idle(3);
    check("s4_fail_c", int'(get_fail(2)), 1);
    check("s4_err_c", act_err(2, 0), 1);

    // CNT_W=2 saturation and clear semantics
    prep();
    for (int j = 0; j < 5; j++) step(4'h1, 4'h0, 0, 0, 0);
    check("s5_sat_b", act_err(1, 0), 3);
    step(4'h0, 4'h0, 0, 1, 0);
    check("s5_clr_b", act_err(1, 0), 0);
    step(4'h1, 4'h0, 0, 1, 0);
    check("s5_clr_viol_b", act_err(1, 0), 1);

    // DELAY=2: reset drops pending obligations, then channels independent
    prep();
    idle(1);
    step(4'hF, 4'h0, 0, 0, 0);
    step(4'h0, 4'h0, 0, 0, 1);
    check("s6_rst_fail_d", int'(get_fail(3)), 0);
    idle(1);
    check("s6_nofail_d", int'(get_fail(3)), 0);
    check("s6_err_d", int'(get_err(3)), 0);
    idle(1);
    step(4'h5, 4'h0, 0, 0, 0); idle(1);
    step(4'h0, 4'h1, 0, 0, 0);
    check("s6_fail_ch2", int'(get_fail(3)), 4);
    check("s6_err_ch2", act_err(3, 2), 1);
    check("s6_err_ch0", act_err(3, 0), 0);

    // Randomized traffic with occasional disable, clear, reset and X on inputs
    for (int n = 0; n < 1500; n++) begin
      a = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) c[$urandom_range(0, 3)] = 1'bx;
      if ($urandom_range(0, 29) == 0) a[$urandom_range(0, 3)] = 1'bx;
      step(a, c, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
